// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and small-sigma helpers for the message schedule.
package sha256_pkg;

    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned BLOCK_BITS      = 512;
    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam int unsigned ROUNDS          = 64;
    localparam int unsigned T_W             = $clog2(ROUNDS);

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        LOAD,
        DONE
    } sched_state_t;

    // Rotate right by a constant amount.
    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_BITS - n));
    endfunction

    function automatic word_t sigma0_small(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1_small(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational schedule-word generator over a 16-word window.
//   window : W[t..15] followed by W[0..t-1] for t<16, W[t-16..t-1] for t>=16
//   t      : round index 0..63
//   next_w : schedule word W[t] (window word for t<16, expanded word otherwise)
module sha256_w_expand
    import sha256_pkg::*;
(
    input  word_t          window [WORDS_PER_BLOCK],
    input  logic [T_W-1:0] t,
    output word_t          next_w
);

    word_t expanded;

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], modulo 2^32.
    assign expanded = sigma1_small(window[14]) + window[9]
                    + sigma0_small(window[1]) + window[0];

    assign next_w = (t < T_W'(WORDS_PER_BLOCK)) ? window[0] : expanded;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams W[0..63] for each 512-bit block over valid/ready.
//   clk, rst        : clock, synchronous active-high reset
//   start           : capture padded_message/num_blocks (honoured in IDLE only)
//   padded_message  : bit 0 = MSB of block 0 word 0, block b at [512b +: 512]
//   num_blocks      : 1..MAX_BLOCKS, anything else pulses err
//   busy            : high while the message is being streamed
//   w_valid/w_ready : handshake for w_word, w_index, w_block, w_last
//   done            : one-cycle pulse after the final word is accepted
//   err             : one-cycle pulse on start with an illegal num_blocks
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BLOCKS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [0:BLOCK_BITS*MAX_BLOCKS-1] padded_message,
    input  logic [1:0]                       num_blocks,
    output logic                             busy,
    output logic                             w_valid,
    input  logic                             w_ready,
    output logic [31:0]                      w_word,
    output logic [5:0]                       w_index,
    output logic                             w_block,
    output logic                             w_last,
    output logic                             done,
    output logic                             err
);

    sched_state_t state_q, state_d;
    logic [T_W-1:0] t_q, t_d;
    logic           blk_q, blk_d;
    logic [1:0]     nblk_q, nblk_d;
    word_t          window_q [WORDS_PER_BLOCK];
    word_t          window_d [WORDS_PER_BLOCK];
    logic [0:BLOCK_BITS*MAX_BLOCKS-1] msg_q;

    logic  nb_legal, capture, handshake, last_blk;
    logic  err_d, w_last_d;
    word_t word_d;

    assign nb_legal  = (num_blocks != 2'd0) && (32'(num_blocks) <= MAX_BLOCKS);
    assign handshake = w_valid && w_ready;
    assign last_blk  = ({1'b0, blk_q} == (nblk_q - 2'd1));

    assign w_index = t_q;
    assign w_block = blk_q;

    // Next-state, counter and window update.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        blk_d    = blk_q;
        nblk_d   = nblk_q;
        window_d = window_q;
        capture  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && nb_legal) begin
                    state_d = EMIT;
                    capture = 1'b1;
                    nblk_d  = num_blocks;
                    t_d     = '0;
                    blk_d   = 1'b0;
                    for (int j = 0; j < WORDS_PER_BLOCK; j++)
                        window_d[j] = padded_message[WORD_BITS*j +: WORD_BITS];
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (t_q == T_W'(ROUNDS - 1)) begin
                        state_d = last_blk ? DONE : LOAD;
                    end else begin
                        // The word just accepted is recycled into the tail of the window.
                        t_d = t_q + T_W'(1);
                        for (int j = 0; j < WORDS_PER_BLOCK - 1; j++)
                            window_d[j] = window_q[j+1];
                        window_d[WORDS_PER_BLOCK-1] = w_word;
                    end
                end
            end
            LOAD: begin
                state_d = EMIT;
                t_d     = '0;
                blk_d   = blk_q + 1'b1;
                for (int j = 0; j < WORDS_PER_BLOCK; j++)
                    window_d[j] = msg_q[BLOCK_BITS*32'(blk_d) + WORD_BITS*j +: WORD_BITS];
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        w_last_d = (state_d == EMIT) && (t_d == T_W'(ROUNDS - 1))
                && ({1'b0, blk_d} == (nblk_d - 2'd1));
    end

    // Word generator runs on the next window so w_word is registered in step with w_valid.
    sha256_w_expand u_expand (
        .window (window_d),
        .t      (t_d),
        .next_w (word_d)
    );

    // State, window and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            blk_q   <= 1'b0;
            nblk_q  <= '0;
            for (int j = 0; j < WORDS_PER_BLOCK; j++)
                window_q[j] <= '0;
            busy    <= 1'b0;
            w_valid <= 1'b0;
            w_word  <= '0;
            w_last  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            blk_q    <= blk_d;
            nblk_q   <= nblk_d;
            window_q <= window_d;
            busy     <= (state_d == EMIT) || (state_d == LOAD);
            w_valid  <= (state_d == EMIT);
            w_word   <= word_d;
            w_last   <= w_last_d;
            done     <= (state_d == DONE);
            err      <= err_d;
        end
    end

    // Message store; only written on an accepted start.
    always_ff @(posedge clk) begin
        if (capture)
            msg_q <= padded_message;
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: software schedule model + scoreboard.
module tb_sha256_msg_schedule;

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  t;
        logic        b;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [0:1023] padded_message;
    logic [1:0]    num_blocks;
    logic          busy, w_valid, w_ready, w_block, w_last, done, err;
    logic [31:0]   w_word;
    logic [5:0]    w_index;

    int   total = 0;
    int   bad   = 0;
    int   ready_mode = 0;
    exp_t sbq[$];

    sha256_msg_schedule dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .padded_message (padded_message),
        .num_blocks     (num_blocks),
        .busy           (busy),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_word         (w_word),
        .w_index        (w_index),
        .w_block        (w_block),
        .w_last         (w_last),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference schedule: full 64-word expansion from first principles.
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] sched_word(input logic [0:1023] m, input int b, input int t);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                w[i] = m[512*b + 32*i +: 32];
            end else begin
                s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
                s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
                w[i] = 32'(longint'(s1) + longint'(w[i-7]) + longint'(s0) + longint'(w[i-16]));
            end
        end
        return w[t];
    endfunction

    function automatic logic [0:1023] rand_msg();
        logic [0:1023] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_msg(input logic [0:1023] m, input int nb);
        exp_t e;
        for (int b = 0; b < nb; b++)
            for (int t = 0; t < 64; t++) begin
                e.w    = sched_word(m, b, t);
                e.t    = 6'(t);
                e.b    = 1'(b);
                e.last = (b == nb - 1) && (t == 63);
                sbq.push_back(e);
            end
    endtask

    task automatic do_start(input logic [0:1023] m, input logic [1:0] nb);
        @(posedge clk); #1;
        start = 1'b1;
        padded_message = m;
        num_blocks = nb;
        @(posedge clk); #1;
        start = 1'b0;
        padded_message = rand_msg();
        num_blocks = 2'($urandom);
    endtask

    task automatic wait_done(input int budget, input string nm, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'(1));
        chk({nm, "_done_busy_low"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_index(input int idx, input int budget, input string nm);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (w_valid && w_index == 6'(idx) && w_block == 1'b0) found = 1'b1;
        end
        chk({nm, "_reached_index"}, 64'(found), 64'(1));
    endtask

    // Consumer ready: tied high or random per cycle.
    initial begin
        w_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            w_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Compare process: scoreboard per handshake, stall hold, LOAD bubble, done timing.
    initial begin
        logic        pv, pr, done_due;
        logic [39:0] pout;
        int          gap;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; pout = '0; done_due = 1'b0; gap = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_due = 1'b0;
                gap = 0;
                pv = 1'b0;
            end else begin
                chk("done_timing", 64'(done), 64'(done_due));
                done_due = 1'b0;
                if (gap == 1) begin
                    chk("load_bubble", 64'(w_valid), 64'(0));
                    gap = 2;
                end else if (gap == 2) begin
                    chk("after_bubble_valid", 64'(w_valid), 64'(1));
                    gap = 0;
                end
                if (pv && !pr)
                    chk("stall_hold", 64'({w_valid, w_word, w_index, w_block, w_last}), 64'({1'b1, pout}));
                if (w_valid && w_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_word", 64'(sbq.size()), 64'(1));
                    end else begin
                        e = sbq.pop_front();
                        chk("w_word", 64'(w_word), 64'(e.w));
                        chk("w_index", 64'(w_index), 64'(e.t));
                        chk("w_block", 64'(w_block), 64'(e.b));
                        chk("w_last", 64'(w_last), 64'(e.last));
                        if (e.last) done_due = 1'b1;
                        else if (e.t == 6'd63) gap = 1;
                    end
                end
                pv = w_valid;
                pr = w_ready;
                pout = {w_word, w_index, w_block, w_last};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:1023] abc, m2;
        int cyc;

        rst = 1'b1; start = 1'b0; padded_message = '0; num_blocks = 2'd0;
        abc = '0;
        abc[0:31]    = 32'h61626380;
        abc[480:511] = 32'h00000018;

        // Pin the model to known "abc" values.
        chk("model_w0",  64'(sched_word(abc, 0, 0)),  64'h61626380);
        chk("model_w1",  64'(sched_word(abc, 0, 1)),  64'h0);
        chk("model_w15", 64'(sched_word(abc, 0, 15)), 64'h18);
        chk("model_w16", 64'(sched_word(abc, 0, 16)), 64'h61626380);
        chk("model_w17", 64'(sched_word(abc, 0, 17)), 64'h000F0000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({busy, w_valid, done, err, w_word, w_index, w_block, w_last}), 64'(0));
        rst = 1'b0;

        // 1: "abc", ready tied high.
        push_msg(abc, 1);
        do_start(abc, 2'd1);
        chk("t1_valid_busy", 64'({w_valid, busy}), 64'(2'b11));
        chk("t1_w0_literal", 64'(w_word), 64'h61626380);
        chk("t1_index0", 64'(w_index), 64'(0));
        wait_done(200, "t1", cyc);
        chk("t1_cycles", 64'(cyc), 64'(65));
        chk("t1_drained", 64'(sbq.size()), 64'(0));
        @(negedge clk);
        chk("t1_done_single", 64'({done, busy, w_valid}), 64'(0));

        // 2: "abc" with random back-pressure.
        ready_mode = 1;
        push_msg(abc, 1);
        do_start(abc, 2'd1);
        wait_done(2000, "t2", cyc);
        chk("t2_drained", 64'(sbq.size()), 64'(0));
        ready_mode = 0;

        // 3: two random blocks, ready tied high.
        m2 = rand_msg();
        chk("model_b1_w0", 64'(sched_word(m2, 1, 0)), 64'(m2[512:543]));
        push_msg(m2, 2);
        do_start(m2, 2'd2);
        wait_done(400, "t3", cyc);
        chk("t3_cycles", 64'(cyc), 64'(130));
        chk("t3_drained", 64'(sbq.size()), 64'(0));

        // 4: illegal block counts.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            start = 1'b1;
            padded_message = rand_msg();
            num_blocks = (k == 0) ? 2'd0 : 2'd3;
            @(posedge clk); #1;
            start = 1'b0;
            chk("t4_err_pulse", 64'({err, busy, w_valid}), 64'(3'b100));
            @(posedge clk); #1;
            chk("t4_err_clear", 64'({err, busy, w_valid}), 64'(0));
        end

        // 5: start re-asserted mid-stream is ignored.
        m2 = rand_msg();
        push_msg(m2, 2);
        ready_mode = 1;
        do_start(m2, 2'd2);
        wait_index(20, 500, "t5");
        start = 1'b1;
        num_blocks = 2'd1;
        for (int k = 0; k < 3; k++) begin
            padded_message = rand_msg();
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(3000, "t5", cyc);
        chk("t5_drained", 64'(sbq.size()), 64'(0));
        ready_mode = 0;

        // 6: reset at t=40, then a fresh "abc".
        push_msg(abc, 1);
        do_start(abc, 2'd1);
        wait_index(40, 200, "t6");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_reset_outputs", 64'({busy, w_valid, done, err, w_word, w_index, w_block, w_last}), 64'(0));
        sbq.delete();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", 64'({done, w_valid}), 64'(0));
        end
        push_msg(abc, 1);
        do_start(abc, 2'd1);
        chk("t6_w0_literal", 64'(w_word), 64'h61626380);
        wait_done(200, "t6", cyc);
        chk("t6_cycles", 64'(cyc), 64'(65));
        chk("t6_drained", 64'(sbq.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
